// File: rtl/vga_sync_decoder.sv
// VGA sync decoder: measures incoming line/frame timing, locks onto a stable stream and
// recovers active-area pixel coordinates and pixel data. All state advances on pix_ce.
module vga_sync_decoder #(
  parameter bit          H_POL       = 1'b0,
  parameter bit          V_POL       = 1'b0,
  parameter int unsigned H_ACT_START = 144,
  parameter int unsigned V_ACT_START = 35,
  parameter int unsigned H_ACT_LEN   = 640,
  parameter int unsigned V_ACT_LEN   = 480,
  parameter int unsigned LOCK_LINES  = 4
) (
  input  logic        board_clk,
  input  logic        reset,
  input  logic        pix_ce,
  input  logic        h_sync_in,
  input  logic        v_sync_in,
  input  logic [2:0]  rgb_in,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        pix_valid,
  output logic [2:0]  rgb_out,
  output logic [10:0] line_len,
  output logic [9:0]  frame_lines,
  output logic        locked,
  output logic        frame_start,
  output logic        sync_err
);

  localparam int unsigned       MatchW    = $clog2(LOCK_LINES + 1);
  localparam logic [10:0]       HActStart = 11'(H_ACT_START);
  localparam logic [10:0]       HActEnd   = 11'(H_ACT_START + H_ACT_LEN);
  localparam logic [9:0]        VActStart = 10'(V_ACT_START);
  localparam logic [9:0]        VActEnd   = 10'(V_ACT_START + V_ACT_LEN);
  localparam logic [MatchW-1:0] LockLines = MatchW'(LOCK_LINES);

  typedef enum logic [1:0] {StSearch, StMeasure, StArmed, StLocked} state_e;

  state_e            state_q, state_d;
  logic              h_prev_q, v_prev_q;
  logic [10:0]       hcnt_q, hcnt_d, ref_len_q, ref_len_d, meas_len, h_off;
  logic [9:0]        vcnt_q, vcnt_d, v_off;
  logic [MatchW-1:0] match_cnt_q, match_cnt_d;
  logic              hedge, vedge, len_match, hcnt_sat, vcnt_sat;
  logic              lost_lock, in_window, go_locked;

  // Sync assertion edges, qualified by the pixel strobe.
  always_comb begin
    hedge = pix_ce && (h_sync_in == H_POL) && (h_prev_q != H_POL);
    vedge = pix_ce && (v_sync_in == V_POL) && (v_prev_q != V_POL);
  end

  // Saturating sample and line counters; vsync restart wins over a same-sample hsync.
  always_comb begin
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (pix_ce) begin
      if (hedge) begin
        hcnt_d = '0;
      end else if (hcnt_q != '1) begin
        hcnt_d = hcnt_q + 11'd1;
      end
      if (vedge) begin
        vcnt_d = '0;
      end else if (hedge && (vcnt_q != '1)) begin
        vcnt_d = vcnt_q + 10'd1;
      end
    end
  end

  assign meas_len  = hcnt_q + 11'd1;
  assign len_match = (meas_len == ref_len_q);
  assign hcnt_sat  = pix_ce && (hcnt_d == '1);
  assign vcnt_sat  = pix_ce && (vcnt_d == '1);

  // Lock state machine next-state: count equal lines, arm, then lock on the next vsync.
  always_comb begin
    state_d     = state_q;
    ref_len_d   = ref_len_q;
    match_cnt_d = match_cnt_q;
    lost_lock   = 1'b0;
    unique case (state_q)
      StSearch: begin
        // The partial line before the first hsync edge is discarded.
        if (hedge) begin
          state_d     = StMeasure;
          ref_len_d   = '0;
          match_cnt_d = '0;
        end
      end
      StMeasure: begin
        if (hcnt_sat) begin
          state_d = StSearch;
        end else if (hedge) begin
          if (len_match) begin
            match_cnt_d = match_cnt_q + MatchW'(1);
          end else begin
            ref_len_d   = meas_len;
            match_cnt_d = MatchW'(1);
          end
          if (match_cnt_d >= LockLines) state_d = StArmed;
        end
      end
      StArmed: begin
        if (hcnt_sat) begin
          state_d = StSearch;
        end else if (hedge && !len_match) begin
          state_d     = StMeasure;
          ref_len_d   = meas_len;
          match_cnt_d = MatchW'(1);
        end else if (vedge) begin
          state_d = StLocked;
        end
      end
      StLocked: begin
        if (hcnt_sat || vcnt_sat || (hedge && !len_match)) begin
          state_d   = StSearch;
          lost_lock = 1'b1;
        end
      end
      default: state_d = StSearch;
    endcase
  end

  // Active window from post-update counters.
  always_comb begin
    go_locked = (state_d == StLocked);
    in_window = (hcnt_d >= HActStart) && (hcnt_d < HActEnd) &&
                (vcnt_d >= VActStart) && (vcnt_d < VActEnd);
    h_off     = hcnt_d - HActStart;
    v_off     = vcnt_d - VActStart;
  end

  // State and registered outputs; pulses are refreshed every board_clk, the rest on pix_ce.
  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      state_q     <= StSearch;
      h_prev_q    <= ~H_POL;
      v_prev_q    <= ~V_POL;
      hcnt_q      <= '0;
      vcnt_q      <= '0;
      ref_len_q   <= '0;
      match_cnt_q <= '0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_valid   <= 1'b0;
      rgb_out     <= '0;
      line_len    <= '0;
      frame_lines <= '0;
      locked      <= 1'b0;
      frame_start <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      frame_start <= vedge && (state_q == StLocked) && !lost_lock;
      sync_err    <= lost_lock;
      if (pix_ce) begin
        h_prev_q    <= h_sync_in;
        v_prev_q    <= v_sync_in;
        hcnt_q      <= hcnt_d;
        vcnt_q      <= vcnt_d;
        state_q     <= state_d;
        ref_len_q   <= ref_len_d;
        match_cnt_q <= match_cnt_d;
        if (vedge) frame_lines <= vcnt_q + {9'd0, hedge};
        locked      <= go_locked;
        line_len    <= go_locked ? ref_len_d : '0;
        pix_valid   <= go_locked && in_window;
        pix_x       <= (go_locked && in_window) ? h_off[9:0] : '0;
        pix_y       <= (go_locked && in_window) ? v_off : '0;
        rgb_out     <= (go_locked && in_window) ? rgb_in : '0;
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder on a scaled-down 60x24 raster (hsync 8 samples,
// vsync 2 lines, pix_ce every 4th clock). A second instance runs with inverted polarity.
`timescale 1ns/1ps
module tb_vga_sync_decoder;

  localparam int LINE  = 60;
  localparam int HS    = 8;
  localparam int VS    = 2;
  localparam int FRAME = 24;

  logic       board_clk = 1'b0;
  logic       reset, pix_ce, h_sync, v_sync, h_sync_n, v_sync_n;
  logic [2:0] rgb_in;

  logic [9:0]  pix_x, pix_y, frame_lines, i_pix_x, i_pix_y, i_frame_lines;
  logic        pix_valid, locked, frame_start, sync_err;
  logic        i_pix_valid, i_locked, i_frame_start, i_sync_err;
  logic [2:0]  rgb_out, i_rgb_out;
  logic [10:0] line_len, i_line_len;

  int n_cmp = 0, n_err = 0;
  int se_cnt = 0, fs_cnt = 0, se_cnt_i = 0, fs_cnt_i = 0;
  bit chk_pix = 1'b0;

  assign h_sync_n = ~h_sync;
  assign v_sync_n = ~v_sync;

  always #5 board_clk = ~board_clk;

  vga_sync_decoder #(
    .H_POL(1'b0), .V_POL(1'b0), .H_ACT_START(12), .V_ACT_START(4),
    .H_ACT_LEN(40), .V_ACT_LEN(16), .LOCK_LINES(4)
  ) dut (
    .board_clk(board_clk), .reset(reset), .pix_ce(pix_ce), .h_sync_in(h_sync),
    .v_sync_in(v_sync), .rgb_in(rgb_in), .pix_x(pix_x), .pix_y(pix_y),
    .pix_valid(pix_valid), .rgb_out(rgb_out), .line_len(line_len),
    .frame_lines(frame_lines), .locked(locked), .frame_start(frame_start),
    .sync_err(sync_err)
  );

  vga_sync_decoder #(
    .H_POL(1'b1), .V_POL(1'b1), .H_ACT_START(12), .V_ACT_START(4),
    .H_ACT_LEN(40), .V_ACT_LEN(16), .LOCK_LINES(4)
  ) dut_inv (
    .board_clk(board_clk), .reset(reset), .pix_ce(pix_ce), .h_sync_in(h_sync_n),
    .v_sync_in(v_sync_n), .rgb_in(rgb_in), .pix_x(i_pix_x), .pix_y(i_pix_y),
    .pix_valid(i_pix_valid), .rgb_out(i_rgb_out), .line_len(i_line_len),
    .frame_lines(i_frame_lines), .locked(i_locked), .frame_start(i_frame_start),
    .sync_err(i_sync_err)
  );

  // Pulse-width accounting: each event must add exactly one high cycle.
  always @(negedge board_clk) begin
    if (sync_err)      se_cnt   <= se_cnt + 1;
    if (frame_start)   fs_cnt   <= fs_cnt + 1;
    if (i_sync_err)    se_cnt_i <= se_cnt_i + 1;
    if (i_frame_start) fs_cnt_i <= fs_cnt_i + 1;
  end

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] pix_rgb(input int l, input int c);
    return 3'(((c + l) % 7) + 1);
  endfunction

  // One strobed sample, then three idle clocks with junk on the sync/rgb inputs.
  task automatic send_sample(input bit hs_act, input bit vs_act, input logic [2:0] rgb);
    h_sync = ~hs_act;
    v_sync = ~vs_act;
    rgb_in = rgb;
    pix_ce = 1'b1;
    @(posedge board_clk); #1;
    pix_ce = 1'b0;
    h_sync = 1'($urandom);
    v_sync = 1'($urandom);
    rgb_in = 3'($urandom);
    repeat (3) begin
      @(posedge board_clk); #1;
    end
  endtask

  task automatic check_pixel(input int l, input int c);
    bit v;
    v = (c >= 12) && (c < 52) && (l >= 4) && (l < 20);
    check_eq($sformatf("pix_valid@%0d,%0d", l, c), 32'(pix_valid), v ? 1 : 0);
    check_eq($sformatf("pix_x@%0d,%0d", l, c), 32'(pix_x), v ? c - 12 : 0);
    check_eq($sformatf("pix_y@%0d,%0d", l, c), 32'(pix_y), v ? l - 4 : 0);
    check_eq($sformatf("rgb_out@%0d,%0d", l, c), 32'(rgb_out), v ? 32'(pix_rgb(l, c)) : 0);
  endtask

  task automatic send_line(input int l, input int len);
    for (int c = 0; c < len; c++) begin
      send_sample(c < HS, l < VS, pix_rgb(l, c));
      if (chk_pix && ((l == 4 && (c == 12 || c == 51 || c == 52)) ||
                      (c == 20 && (l == 3 || l == 19 || l == 20))))
        check_pixel(l, c);
    end
  endtask

  task automatic send_lines(input int first, input int last);
    for (int l = first; l <= last; l++) send_line(l, LINE);
  endtask

  task automatic check_state(input string tag, input int exp_locked, input int exp_len);
    check_eq({tag, ".locked"}, 32'(locked), exp_locked);
    check_eq({tag, ".line_len"}, 32'(line_len), exp_len);
    check_eq({tag, ".inv_locked"}, 32'(i_locked), exp_locked);
    check_eq({tag, ".inv_line_len"}, 32'(i_line_len), exp_len);
  endtask

  task automatic check_pix_zero(input string tag);
    check_eq({tag, ".pix_valid"}, 32'(pix_valid), 0);
    check_eq({tag, ".pix_x"}, 32'(pix_x), 0);
    check_eq({tag, ".pix_y"}, 32'(pix_y), 0);
    check_eq({tag, ".rgb_out"}, 32'(rgb_out), 0);
  endtask

  initial begin
    int k, se0;
    reset  = 1'b1;
    pix_ce = 1'b0;
    h_sync = 1'b1;
    v_sync = 1'b1;
    rgb_in = 3'd0;
    repeat (3) @(posedge board_clk);
    #1;
    check_state("rst", 0, 0);
    check_pix_zero("rst");
    check_eq("rst.frame_lines", 32'(frame_lines), 0);
    check_eq("rst.frame_start", 32'(frame_start), 0);
    check_eq("rst.sync_err", 32'(sync_err), 0);
    check_eq("rst.inv_frame_lines", 32'(i_frame_lines), 0);
    reset = 1'b0;

    // Acquire: armed after 5 hsyncs, locked only at the following vsync.
    send_lines(0, FRAME - 1);
    check_state("acq_f0", 0, 0);
    send_line(0, LINE);
    check_state("acq_f1", 1, LINE);
    check_eq("acq.frame_lines", 32'(frame_lines), FRAME);
    check_eq("acq.inv_frame_lines", 32'(i_frame_lines), FRAME);
    check_eq("acq.frame_start_cnt", fs_cnt, 0);
    chk_pix = 1'b1;
    send_lines(1, FRAME - 1);
    chk_pix = 1'b0;
    send_line(0, LINE);
    check_eq("f2.frame_start_cnt", fs_cnt, 1);
    check_eq("f2.inv_frame_start_cnt", fs_cnt_i, 1);
    check_eq("f2.frame_lines", 32'(frame_lines), FRAME);
    check_state("f2", 1, LINE);

    // Short line drops lock, then four good lines and a vsync restore it.
    send_lines(1, 4);
    send_line(5, LINE - 1);
    send_line(6, LINE);
    check_eq("short.sync_err_cnt", se_cnt, 1);
    check_eq("short.inv_sync_err_cnt", se_cnt_i, 1);
    check_state("short", 0, 0);
    check_pix_zero("short");
    send_lines(7, 10);
    check_state("rearm", 0, 0);
    send_lines(11, FRAME - 1);
    send_line(0, LINE);
    check_state("relock", 1, LINE);
    check_eq("relock.sync_err_cnt", se_cnt, 1);
    check_eq("relock.frame_start_cnt", fs_cnt, 1);
    check_eq("relock.frame_lines", 32'(frame_lines), FRAME);

    // Missing hsync: hcnt runs from 59 up to 2047, i.e. 1988 more samples.
    send_line(1, LINE);
    se0 = se_cnt;
    k = 0;
    while (se_cnt == se0 && k < 2100) begin
      send_sample(1'b0, 1'b0, 3'd5);
      k++;
    end
    check_eq("hold.samples", k, 1988);
    check_eq("hold.sync_err_cnt", se_cnt, 2);
    check_eq("hold.inv_sync_err_cnt", se_cnt_i, 2);
    check_state("hold", 0, 0);
    check_pix_zero("hold");
    repeat (10) send_sample(1'b0, 1'b0, 3'd5);
    check_eq("hold.no_extra_err", se_cnt, 2);

    // Lock again, then reset mid-line inside the active window.
    send_lines(0, FRAME - 1);
    send_lines(0, 9);
    for (int c = 0; c <= 30; c++) send_sample(c < HS, 1'b0, pix_rgb(10, c));
    check_eq("mid.locked", 32'(locked), 1);
    check_eq("mid.pix_valid", 32'(pix_valid), 1);
    check_eq("mid.pix_x", 32'(pix_x), 18);
    check_eq("mid.pix_y", 32'(pix_y), 6);
    check_eq("mid.rgb_out", 32'(rgb_out), 32'(pix_rgb(10, 30)));
    #2 reset = 1'b1;
    #1;
    check_state("arst", 0, 0);
    check_pix_zero("arst");
    check_eq("arst.frame_lines", 32'(frame_lines), 0);
    @(posedge board_clk); #1;
    @(posedge board_clk); #1;
    reset = 1'b0;
    send_lines(0, FRAME - 1);
    check_state("post_rst_f0", 0, 0);
    send_line(0, LINE);
    check_state("post_rst_f1", 1, LINE);
    check_eq("post_rst.frame_lines", 32'(frame_lines), FRAME);
    check_eq("post_rst.inv_frame_lines", 32'(i_frame_lines), FRAME);
    check_eq("post_rst.sync_err_cnt", se_cnt, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
